mem_stage: RTL

//  Pipeline MEM stage. Consumes the execute stage's load/store outputs (aluop, mem_addr, reg2) and its writeback triple.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM encoding and opcode classifiers for the MEM stage.
// Imported by mem_stage, mem_lane_align and the bench.
package mem_stage_pkg;

    localparam logic [4:0] LW_OP = 5'h10;
    localparam logic [4:0] SW_OP = 5'h11;
    localparam logic [4:0] LB_OP = 5'h12;
    localparam logic [4:0] SB_OP = 5'h13;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == LW_OP) || (op == SW_OP) || (op == LB_OP) || (op == SB_OP);
    endfunction

    function automatic logic is_load_op(input logic [4:0] op);
        return (op == LW_OP) || (op == LB_OP);
    endfunction

    function automatic logic is_store_op(input logic [4:0] op);
        return (op == SW_OP) || (op == SB_OP);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store data replication, load extraction/sign-extension, fault flags.
// Latency: combinational. Backpressure: none. Byte ops enabled by MEM_BYTE_EN.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign,
    output logic        unsupported
);

`ifdef MEM_BYTE_EN
    logic [7:0] rbyte;
    assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
`endif

    always_comb begin
        be          = 4'b1111;
        wdata       = reg2;
        ldata       = rdata;
        misalign    = 1'b0;
        unsupported = 1'b0;
        case (op)
            LW_OP, SW_OP: misalign = (addr_lo != 2'b00);
`ifdef MEM_BYTE_EN
            LB_OP, SB_OP: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{reg2[7:0]}};
                ldata = {{24{rbyte[7]}}, rbyte};
            end
`else
            LB_OP, SB_OP: unsupported = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus, passes other ops straight to WB.
// Latency: 0 for non-memory ops; memory ops occupy IDLE + REQ cycles + DONE (min 3), stall high until DONE.
// Backpressure: dmem_ack_i gates completion; ACK_TIMEOUT bounds the wait. MEM_BYTE_EN enables LB/SB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        stall_from_mem,
    output logic        err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q;
    logic [4:0]  op_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] ldata_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic        req_q;
    logic        err_q;

    logic        mem_op_in;
    logic        in_req;
    logic        timeout;
    logic        bad_op;
    logic [4:0]  al_op;
    logic [1:0]  al_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_misalign;
    logic        al_unsup;

    assign mem_op_in = is_mem_op(aluop_i);
    assign in_req    = (state_q == MEM_REQ);
    assign timeout   = (cnt_q == 8'(ACK_TIMEOUT - 1));
    assign bad_op    = al_misalign || al_unsup;

    // Aligner sees the live op while accepting, and the latched op while waiting for read data.
    assign al_op   = (state_q == MEM_IDLE) ? aluop_i : op_q;
    assign al_addr = (state_q == MEM_IDLE) ? mem_addr_i[1:0] : addr_q[1:0];

    mem_lane_align u_align (
        .op          (al_op),
        .addr_lo     (al_addr),
        .reg2        (reg2_i),
        .rdata       (dmem_rdata_i),
        .be          (al_be),
        .wdata       (al_wdata),
        .ldata       (al_ldata),
        .misalign    (al_misalign),
        .unsupported (al_unsup)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (mem_op_in) state_d = bad_op ? MEM_DONE : MEM_REQ;
            MEM_REQ:  if (dmem_ack_i || timeout) state_d = MEM_DONE;
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 5'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            ldata_q <= 32'd0;
            waddr_q <= 5'd0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == MEM_REQ);
            err_q   <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    cnt_q <= 8'd0;
                    if (mem_op_in) begin
                        op_q    <= aluop_i;
                        addr_q  <= mem_addr_i;
                        be_q    <= al_be;
                        wdata_q <= al_wdata;
                        waddr_q <= waddr_i;
                        we_q    <= we_i;
                        ldata_q <= 32'd0;
                        err_q   <= bad_op;
                    end
                end
                MEM_REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Ack beats a coincident timeout.
                    if (dmem_ack_i) ldata_q <= al_ldata;
                    else if (timeout) err_q <= 1'b1;
                end
                default: cnt_q <= 8'd0;
            endcase
        end
    end

    assign err_o        = err_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = in_req && is_store_op(op_q);
    assign dmem_be_o    = in_req ? be_q : 4'd0;
    assign dmem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_o = in_req ? wdata_q : 32'd0;

    always_comb begin
        stall_from_mem = NO_STOP;
        we_o           = 1'b0;
        waddr_o        = 5'd0;
        wdata_o        = 32'd0;
        if (rst) begin
            case (state_q)
                MEM_IDLE: begin
                    if (mem_op_in) begin
                        stall_from_mem = STOP;
                    end else begin
                        we_o    = we_i;
                        waddr_o = waddr_i;
                        wdata_o = wdata_i;
                    end
                end
                MEM_REQ: stall_from_mem = STOP;
                MEM_DONE: begin
                    we_o    = we_q && is_load_op(op_q) && !err_q;
                    waddr_o = waddr_q;
                    wdata_o = ldata_q;
                end
                default: ;
            endcase
        end
    end

endmodule
